// File: rtl/conv_pkg.sv
// Shared definitions for the filtered-image streamer: bus widths, FSM states
// and the layout of one buffered pixel (data plus row/frame markers).
package conv_pkg;

  localparam int ADDR_W  = 16;
  localparam int PIX_W   = 8;
  localparam int ENTRY_W = PIX_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sol;
    logic             last;
  } pix_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO with the head always held in entry 0, so dout is a plain
// register output and stays stable while the consumer stalls.
module skid_fifo2
  import conv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] din,
  input  logic               pop,
  output logic [ENTRY_W-1:0] dout,
  output logic               empty,
  output logic [1:0]         count
);

  logic [ENTRY_W-1:0] entry0;
  logic [ENTRY_W-1:0] entry1;
  logic [1:0]         cnt;
  logic               do_pop;
  logic               do_push;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  // NOTE: the two storage entries are reset as well, because dout feeds the
  // out_data port directly and that port must read 0 during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry0 <= '0;
      entry1 <= '0;
      cnt    <= 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) entry0 <= din;
          else             entry1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          cnt    <= cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the new word lands behind whatever remains.
          if (cnt == 2'd1) begin
            entry0 <= din;
          end else begin
            entry0 <= entry1;
            entry1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = entry0;
  assign empty = (cnt == 2'd0);
  assign count = cnt;

endmodule

// File: rtl/filt_streamer.sv
// Reads a filtered image out of a one-cycle-latency RAM in raster order and
// presents it as a ready/valid pixel stream with start-of-row and end-of-frame.
module filt_streamer
  import conv_pkg::*;
#(
  parameter int IMG_W = 254,
  parameter int IMG_H = 254
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sol,
  output logic              out_last
);

  localparam int                N         = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(IMG_W - 1);

  state_t             state;
  logic [ADDR_W-1:0]  col;
  logic               inflight;
  logic               inflight_sol;
  logic               inflight_last;
  logic [1:0]         fifo_count;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_dout;
  pix_t               head;
  pix_t               push_pix;
  logic               pop;

  assign head      = pix_t'(fifo_dout);
  assign out_valid = !fifo_empty;
  assign out_data  = head.data;
  assign out_sol   = head.sol;
  assign out_last  = head.last;
  assign pop       = out_valid && out_ready;

  // A read is only issued if its data is guaranteed a FIFO slot on return,
  // counting the pop happening this very cycle.
  assign rd_en = (state == READ) &&
                 (({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign push_pix = '{data: rd_data, sol: inflight_sol, last: inflight_last};

  // Markers travel alongside the read so they line up with returning data.
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight      <= 1'b0;
      inflight_sol  <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) begin
        inflight_sol  <= (col == '0);
        inflight_last <= (rd_addr == LAST_ADDR);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rd_addr <= '0;
      col     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= READ;
            busy    <= 1'b1;
            rd_addr <= '0;
            col     <= '0;
          end
        end
        READ: begin
          if (rd_en) begin
            if (rd_addr == LAST_ADDR) begin
              state <= DRAIN;
            end else begin
              rd_addr <= rd_addr + ADDR_W'(1);
              col     <= (col == COL_LAST) ? '0 : col + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (pop && head.last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  skid_fifo2 u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (push_pix),
    .pop  (pop),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .count(fifo_count)
  );

endmodule
